// File: rtl/seq_delay_line_if.sv
// Bundle of the control, input and output signals of seq_delay_line.
// clk and reset_n are plain ports on the block and are not part of this bundle.
interface seq_delay_line_if #(
   parameter int WIDTH     = 8,
   parameter int MAX_DEPTH = 8
) ();
   localparam int DW = $clog2(MAX_DEPTH + 1);

   // Valid semantics: a word is accepted at a rising edge when in_val=1, en=1
   // and flush=0. There is no back-pressure (no ready). out_val marks a valid
   // word at the selected tap in the current cycle. out_data is forced to zero
   // whenever out_val=0.
   logic             en;
   logic             flush;
   logic [DW-1:0]    dly;
   logic             in_val;
   logic [WIDTH-1:0] in_data;
   logic             out_val;
   logic [WIDTH-1:0] out_data;
   logic [DW-1:0]    count;

   // Producer/consumer side.
   modport master (
      output en, flush, dly, in_val, in_data,
      input  out_val, out_data, count
   );

   // Delay-line side.
   modport slave (
      input  en, flush, dly, in_val, in_data,
      output out_val, out_data, count
   );
endinterface

// File: rtl/seq_delay_line.sv
// Programmable-latency delay pipeline for a data word plus valid bit.
// Supports stall (en=0), synchronous flush of the valid bits and a
// combinational tap select. It also reports how many valid items sit in
// front of the tap.
module seq_delay_line #(
   parameter int WIDTH     = 8,
   parameter int MAX_DEPTH = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   seq_delay_line_if.slave bus
);
   localparam int DW = $clog2(MAX_DEPTH + 1);

   logic [WIDTH-1:0]     s_q [MAX_DEPTH];
   logic [WIDTH-1:0]     s_d [MAX_DEPTH];
   logic [MAX_DEPTH-1:0] v_q;
   logic [MAX_DEPTH-1:0] v_d;

   logic [DW-1:0]        dly_eff;
   logic                 out_val_c;
   logic [WIDTH-1:0]     out_data_c;
   logic [DW-1:0]        count_c;

   // Next stage contents.
   // Flush clears only the valid bits, so stale data stays in the stages
   // and is masked at the output.
   always_comb begin
      s_d = s_q;
      v_d = v_q;
      if (bus.flush) begin
         v_d = '0;
      end else if (bus.en) begin
         v_d[0] = bus.in_val;
         s_d[0] = bus.in_data;
         for (int i = 1; i < MAX_DEPTH; i++) begin
            v_d[i] = v_q[i-1];
            s_d[i] = s_q[i-1];
         end
      end
   end

   // Stage registers with asynchronous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_q <= '{default: '0};
         v_q <= '0;
      end else begin
         s_q <= s_d;
         v_q <= v_d;
      end
   end

   // Clamp the requested delay into 1..MAX_DEPTH.
   // This rules out a combinational bypass.
   always_comb begin
      dly_eff = bus.dly;
      if (bus.dly == '0) begin
         dly_eff = DW'(1);
      end else if (bus.dly > DW'(MAX_DEPTH)) begin
         dly_eff = DW'(MAX_DEPTH);
      end
   end

   // Tap select and popcount of the valid bits in front of the tap.
   always_comb begin
      out_val_c  = 1'b0;
      out_data_c = '0;
      count_c    = '0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
         if (DW'(i) == dly_eff - DW'(1)) begin
            out_val_c  = v_q[i];
            out_data_c = v_q[i] ? s_q[i] : '0;
         end
         if (DW'(i) < dly_eff) begin
            count_c = count_c + DW'(v_q[i]);
         end
      end
   end

   assign bus.out_val  = out_val_c;
   assign bus.out_data = out_data_c;
   assign bus.count    = count_c;
endmodule

// File: tb/tb_seq_delay_line.sv
// Self-checking bench for seq_delay_line (WIDTH=8, MAX_DEPTH=8).
// The reference model keeps a history of pushed words plus a count of
// pushes since the last flush. It has no per-stage valid registers.
module tb_seq_delay_line;
   localparam int W  = 8;
   localparam int MD = 8;
   localparam int DW = $clog2(MD + 1);

   logic clk;
   logic reset_n;
   int   n_cmp;
   int   n_fail;

   seq_delay_line_if #(.WIDTH(W), .MAX_DEPTH(MD)) bus ();

   seq_delay_line #(.WIDTH(W), .MAX_DEPTH(MD)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   logic [W:0] hist[$];   // {val,data}; index 0 = newest word pushed
   int         since_flush;

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < MD; i++) hist.push_back('0);
      since_flush = 0;
   endtask

   task automatic model_edge(input logic e, input logic f, input logic iv, input logic [W-1:0] d);
      if (f) begin
         since_flush = 0;
      end else if (e) begin
         hist.push_front({iv, d});
         void'(hist.pop_back());
         if (since_flush < MD + 1) since_flush++;
      end
   endtask

   function automatic int exp_eff();
      int d;
      d = int'(bus.dly);
      if (d == 0) return 1;
      if (d > MD) return MD;
      return d;
   endfunction

   // An entry at age k is still valid only if it was pushed after the last flush.
   function automatic logic item_valid(input int k);
      return hist[k][W] && (k < since_flush);
   endfunction

   function automatic logic exp_val();
      return item_valid(exp_eff() - 1);
   endfunction

   function automatic logic [W-1:0] exp_data();
      return exp_val() ? hist[exp_eff() - 1][W-1:0] : '0;
   endfunction

   function automatic logic [DW-1:0] exp_count();
      int c;
      c = 0;
      for (int k = 0; k < exp_eff(); k++) c += int'(item_valid(k));
      return DW'(c);
   endfunction

   // ---------------- driver tasks ----------------
   // Drive one cycle of inputs and advance the model at the edge.
   // Return at the following negedge so the caller can sample outputs.
   task automatic step(input logic e, input logic f, input logic iv, input logic [W-1:0] d);
      bus.en      = e;
      bus.flush   = f;
      bus.in_val  = iv;
      bus.in_data = d;
      @(posedge clk);
      model_edge(e, f, iv, d);
      @(negedge clk);
   endtask

   task automatic set_dly(input int d);
      bus.dly = DW'(d);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1;
      n_cmp++; if (bus.out_val !== 1'b0) begin n_fail++; $display("FAIL reset_init_val: got %0b expected 0", bus.out_val); end
      n_cmp++; if (bus.count !== '0) begin n_fail++; $display("FAIL reset_init_count: got %0d expected 0", bus.count); end
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      set_dly(1);
      step(1, 0, 1, 8'h5A);
      n_cmp++; if (bus.out_data !== 8'h5A) begin n_fail++; $display("FAIL reset_pre_data: got %0h expected 5a", bus.out_data); end
      step(1, 0, 1, 8'h5B);
      // asynchronous assert mid-cycle, no clock edge in between
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      n_cmp++; if (bus.out_val !== 1'b0) begin n_fail++; $display("FAIL reset_async_val: got %0b expected 0", bus.out_val); end
      n_cmp++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_async_data: got %0h expected 0", bus.out_data); end
      n_cmp++; if (bus.count !== '0) begin n_fail++; $display("FAIL reset_async_count: got %0d expected 0", bus.count); end
      @(negedge clk);
      reset_n = 1'b1;
      set_dly(8);
      for (int c = 0; c < 10; c++) begin
         step(1, 0, 0, W'($urandom_range(0, 255)));
         n_cmp++; if ({bus.out_val, bus.out_data, bus.count} !== '0) begin
            n_fail++; $display("FAIL reset_idle c=%0d: got val=%0b data=%0h count=%0d expected all 0", c, bus.out_val, bus.out_data, bus.count);
         end
      end
   endtask

   task automatic test_latency();
      int dlys[5];
      int effs[5];
      dlys = '{0, 1, 3, 8, 12};
      effs = '{1, 1, 3, 8, 8};
      for (int t = 0; t < 5; t++) begin
         set_dly(dlys[t]);
         step(1, 1, 0, 8'h00);
         for (int c = 1; c <= 10; c++) begin
            if (c == 1) step(1, 0, 1, 8'hA5);
            else        step(1, 0, 0, 8'h00);
            n_cmp++; if (bus.out_val !== (c == effs[t])) begin
               n_fail++; $display("FAIL latency_val dly=%0d c=%0d: got %0b expected %0b", dlys[t], c, bus.out_val, (c == effs[t]));
            end
            n_cmp++; if (bus.out_data !== ((c == effs[t]) ? 8'hA5 : 8'h00)) begin
               n_fail++; $display("FAIL latency_data dly=%0d c=%0d: got %0h", dlys[t], c, bus.out_data);
            end
            n_cmp++; if (bus.count !== DW'(c <= effs[t])) begin
               n_fail++; $display("FAIL latency_count dly=%0d c=%0d: got %0d expected %0d", dlys[t], c, bus.count, (c <= effs[t]));
            end
         end
      end
   endtask

   task automatic test_stream_bubbles();
      logic [W-1:0] exp_out[12];
      logic         exp_v[12];
      int           peak;
      exp_out = '{default: '0};
      exp_v   = '{default: 1'b0};
      exp_out[4] = 8'h01; exp_v[4] = 1'b1;
      exp_out[5] = 8'h02; exp_v[5] = 1'b1;
      exp_out[7] = 8'h04; exp_v[7] = 1'b1;
      peak = 0;
      set_dly(4);
      step(1, 1, 0, 8'h00);
      for (int c = 1; c < 12; c++) begin
         case (c)
            1:       step(1, 0, 1, 8'h01);
            2:       step(1, 0, 1, 8'h02);
            3:       step(1, 0, 0, 8'h33);
            4:       step(1, 0, 1, 8'h04);
            default: step(1, 0, 0, 8'h00);
         endcase
         if (int'(bus.count) > peak) peak = int'(bus.count);
         n_cmp++; if ({bus.out_val, bus.out_data} !== {exp_v[c], exp_out[c]}) begin
            n_fail++; $display("FAIL stream_out c=%0d: got %0b/%0h expected %0b/%0h", c, bus.out_val, bus.out_data, exp_v[c], exp_out[c]);
         end
         n_cmp++; if (bus.count !== exp_count()) begin
            n_fail++; $display("FAIL stream_count c=%0d: got %0d expected %0d", c, bus.count, exp_count());
         end
      end
      n_cmp++; if (peak !== 3) begin n_fail++; $display("FAIL stream_peak: got %0d expected 3", peak); end
   endtask

   task automatic test_stall();
      logic [W+DW:0] held;
      set_dly(3);
      step(1, 1, 0, 8'h00);
      step(1, 0, 1, 8'h3C);
      held = {bus.out_val, bus.out_data, bus.count};
      for (int c = 2; c <= 6; c++) begin
         step(0, 0, 1, W'($urandom_range(0, 255)));
         n_cmp++; if ({bus.out_val, bus.out_data, bus.count} !== held) begin
            n_fail++; $display("FAIL stall_hold c=%0d: got %0h expected %0h", c, {bus.out_val, bus.out_data, bus.count}, held);
         end
      end
      for (int c = 7; c <= 10; c++) begin
         step(1, 0, 0, 8'h00);
         n_cmp++; if ({bus.out_val, bus.out_data} !== ((c == 8) ? {1'b1, 8'h3C} : 9'h0)) begin
            n_fail++; $display("FAIL stall_out c=%0d: got %0b/%0h expected %0b", c, bus.out_val, bus.out_data, (c == 8));
         end
      end
   endtask

   task automatic test_flush();
      set_dly(8);
      for (int i = 0; i < 8; i++) step(1, 0, 1, W'(i + 1));
      n_cmp++; if (bus.count !== DW'(8)) begin n_fail++; $display("FAIL flush_fill_count: got %0d expected 8", bus.count); end
      step(0, 1, 1, 8'h77);
      n_cmp++; if ({bus.out_val, bus.out_data, bus.count} !== '0) begin
         n_fail++; $display("FAIL flush_clear: got val=%0b data=%0h count=%0d expected all 0", bus.out_val, bus.out_data, bus.count);
      end
      for (int c = 0; c < 12; c++) begin
         step(1, 0, 0, 8'h00);
         n_cmp++; if (bus.out_val !== 1'b0 || bus.out_data === 8'h77 || bus.count !== '0) begin
            n_fail++; $display("FAIL flush_after c=%0d: got val=%0b data=%0h count=%0d expected 0", c, bus.out_val, bus.out_data, bus.count);
         end
      end
   endtask

   task automatic test_dly_change();
      set_dly(8);
      step(1, 1, 0, 8'h00);
      for (int i = 0; i < 8; i++) step(1, 0, 1, 8'h10 + W'(i));
      n_cmp++; if (bus.out_data !== 8'h10) begin n_fail++; $display("FAIL dlychg_tap8: got %0h expected 10", bus.out_data); end
      set_dly(2);
      #1;
      n_cmp++; if ({bus.out_val, bus.out_data, bus.count} !== {1'b1, 8'h16, DW'(2)}) begin
         n_fail++; $display("FAIL dlychg_tap2_now: got %0b/%0h/%0d expected 1/16/2", bus.out_val, bus.out_data, bus.count);
      end
      step(1, 0, 0, 8'h00);
      n_cmp++; if ({bus.out_val, bus.out_data, bus.count} !== {1'b1, 8'h17, DW'(1)}) begin
         n_fail++; $display("FAIL dlychg_tap2_edge: got %0b/%0h/%0d expected 1/17/1", bus.out_val, bus.out_data, bus.count);
      end
      set_dly(8);
      #1;
      n_cmp++; if (bus.count !== DW'(7)) begin n_fail++; $display("FAIL dlychg_back_count: got %0d expected 7", bus.count); end
      for (int j = 0; j < 7; j++) begin
         n_cmp++; if ({bus.out_val, bus.out_data} !== {1'b1, 8'h11 + W'(j)}) begin
            n_fail++; $display("FAIL dlychg_resume j=%0d: got %0b/%0h expected 1/%0h", j, bus.out_val, bus.out_data, 8'h11 + j);
         end
         step(1, 0, 0, 8'h00);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 15) == 0) set_dly($urandom_range(0, 15));
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0),
              1'($urandom_range(0, 1)), W'($urandom_range(0, 255)));
         n_cmp++; if ({bus.out_val, bus.out_data, bus.count} !== {exp_val(), exp_data(), exp_count()}) begin
            n_fail++; $display("FAIL random c=%0d dly=%0d: got %0b/%0h/%0d expected %0b/%0h/%0d", c, bus.dly,
                               bus.out_val, bus.out_data, bus.count, exp_val(), exp_data(), exp_count());
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      n_cmp       = 0;
      n_fail      = 0;
      reset_n     = 1'b0;
      bus.en      = 1'b0;
      bus.flush   = 1'b0;
      bus.dly     = '0;
      bus.in_val  = 1'b0;
      bus.in_data = '0;
      model_reset();
      test_reset();
      test_latency();
      test_stream_bubbles();
      test_stall();
      test_flush();
      test_dly_change();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
